instruction_ctrl: RTL

INSTRUCTION_CTRL -- requirements
Module: instruction_ctrl

---
 rtl/instruction_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/instruction_ctrl.sv
// Instruction controller: synchronises the SPI instruction/mask bytes into iclk
// and executes one command per byte change (ARM, DISARM, SOFT_TRIG, READOUT, RESET_DIGITAL).
module instruction_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RST_CYCLES  = 16,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       iclk,
  input  logic       rstn,
  input  logic [7:0] instruction,
  input  logic [7:0] trigger_channel_mask,
  input  logic       readout_ack,
  output logic [7:0] trig_en,
  output logic       soft_trig,
  output logic       readout_req,
  output logic       dig_rstn_out,
  output logic       busy,
  output logic       cmd_err
);

  localparam int unsigned CNT_MAX = (RST_CYCLES > ACK_TIMEOUT) ? RST_CYCLES : ACK_TIMEOUT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    PULSE,
    WAIT_ACK,
    RST_HOLD
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP       = 4'h0,
    OP_ARM       = 4'h1,
    OP_DISARM    = 4'h2,
    OP_SOFT_TRIG = 4'h3,
    OP_READOUT   = 4'h4,
    OP_RST_DIG   = 4'h5
  } opcode_t;

  logic [SYNC_STAGES-1:0][7:0] instr_sync;
  logic [SYNC_STAGES-1:0][7:0] mask_sync;
  logic [7:0]                  instr_s;
  logic [7:0]                  mask_s;
  logic [7:0]                  instr_q;

  state_t        state, state_d;
  logic [7:0]    last_cmd, last_cmd_d;
  logic [7:0]    trig_en_d;
  logic          armed, armed_d;
  logic          soft_trig_d;
  logic          readout_req_d;
  logic          dig_rstn_d;
  logic          cmd_err_d;
  logic [CW-1:0] cnt, cnt_d;

  assign instr_s = instr_sync[SYNC_STAGES-1];
  assign mask_s  = mask_sync[SYNC_STAGES-1];
  assign busy    = (state != IDLE);

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      instr_sync <= '0;
      mask_sync  <= '0;
      instr_q    <= '0;
    end else begin
      instr_sync[0] <= instruction;
      mask_sync[0]  <= trigger_channel_mask;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        instr_sync[i] <= instr_sync[i-1];
        mask_sync[i]  <= mask_sync[i-1];
      end
      instr_q <= instr_s;
    end
  end

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      last_cmd     <= '0;
      trig_en      <= '0;
      armed        <= 1'b0;
      soft_trig    <= 1'b0;
      readout_req  <= 1'b0;
      dig_rstn_out <= 1'b0;
      cmd_err      <= 1'b0;
      cnt          <= '0;
    end else begin
      state        <= state_d;
      last_cmd     <= last_cmd_d;
      trig_en      <= trig_en_d;
      armed        <= armed_d;
      soft_trig    <= soft_trig_d;
      readout_req  <= readout_req_d;
      dig_rstn_out <= dig_rstn_d;
      cmd_err      <= cmd_err_d;
      cnt          <= cnt_d;
    end
  end

  // last_cmd holds the accepted byte, so DECODE executes from it rather than the live input.
  always_comb begin
    state_d       = state;
    last_cmd_d    = last_cmd;
    trig_en_d     = trig_en;
    armed_d       = armed;
    soft_trig_d   = 1'b0;
    readout_req_d = readout_req;
    dig_rstn_d    = 1'b1;
    cmd_err_d     = cmd_err;
    cnt_d         = cnt;

    unique case (state)
      IDLE: begin
        if ((instr_s == instr_q) && (instr_s != last_cmd)) begin
          last_cmd_d = instr_s;
          state_d    = DECODE;
        end
      end

      DECODE: begin
        state_d = IDLE;
        case (last_cmd[3:0])
          OP_NOP: cmd_err_d = 1'b0;
          OP_ARM: begin
            trig_en_d = mask_s;
            armed_d   = 1'b1;
            cmd_err_d = 1'b0;
          end
          OP_DISARM: begin
            trig_en_d = '0;
            armed_d   = 1'b0;
            cmd_err_d = 1'b0;
          end
          OP_SOFT_TRIG: begin
            if (armed) begin
              soft_trig_d = 1'b1;
              cmd_err_d   = 1'b0;
              state_d     = PULSE;
            end else begin
              cmd_err_d = 1'b1;
            end
          end
          OP_READOUT: begin
            readout_req_d = 1'b1;
            cnt_d         = CW'(ACK_TIMEOUT);
            cmd_err_d     = 1'b0;
            state_d       = WAIT_ACK;
          end
          OP_RST_DIG: begin
            dig_rstn_d = 1'b0;
            cnt_d      = CW'(RST_CYCLES);
            trig_en_d  = '0;
            armed_d    = 1'b0;
            cmd_err_d  = 1'b0;
            state_d    = RST_HOLD;
          end
          default: cmd_err_d = 1'b1;
        endcase
      end

      PULSE: state_d = IDLE;

      // Ack is tested before expiry so a coincident ack counts as success.
      WAIT_ACK: begin
        if (readout_ack) begin
          readout_req_d = 1'b0;
          cnt_d         = '0;
          state_d       = IDLE;
        end else if (cnt <= CW'(1)) begin
          readout_req_d = 1'b0;
          cmd_err_d     = 1'b1;
          cnt_d         = '0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end

      RST_HOLD: begin
        if (cnt <= CW'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          dig_rstn_d = 1'b0;
          cnt_d      = cnt - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
